// File: rtl/alu_exec.sv
// Single-issue 8-bit execution unit: one-cycle ALU ops and an 8-cycle shift-add multiply.
// Results go to a dual-write-port register file; MUL splits its 16-bit product across both ports.
module alu_exec (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] dst,
  output logic       busy,
  output logic       done,
  output logic       w_En,
  output logic [7:0] buf_w1,
  output logic [7:0] buf_w2,
  output logic [2:0] addr_w1,
  output logic [2:0] addr_w2,
  output logic       zf,
  output logic       cf,
  output logic [1:0] dbg_state
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  dst_q, dst_d;
  logic [7:0]  buf_w1_q, buf_w1_d;
  logic [7:0]  buf_w2_q, buf_w2_d;
  logic [2:0]  addr_w1_q, addr_w1_d;
  logic [2:0]  addr_w2_q, addr_w2_d;
  logic        zf_q, zf_d;
  logic        cf_q, cf_d;

  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [7:0]  alu_res;
  logic        alu_cf;
  logic [15:0] prod_next;

  // Single-cycle datapath; diff9[8] is the borrow, i.e. a < b.
  always_comb begin
    sum9    = {1'b0, a} + {1'b0, b};
    diff9   = {1'b0, a} - {1'b0, b};
    alu_res = 8'h00;
    alu_cf  = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum9[7:0];        alu_cf = sum9[8];  end
      OP_SUB: begin alu_res = diff9[7:0];       alu_cf = diff9[8]; end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin alu_res = {a[6:0], 1'b0}; alu_cf = a[7];    end
      OP_SHR: begin alu_res = {1'b0, a[7:1]}; alu_cf = a[0];    end
      default: begin alu_res = 8'h00;          alu_cf = 1'b0;    end
    endcase
  end

  // One multiplier bit per cycle; the last bit's partial sum is written straight to the outputs.
  assign prod_next = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dst_d     = dst_q;
    buf_w1_d  = buf_w1_q;
    buf_w2_d  = buf_w2_q;
    addr_w1_d = addr_w1_q;
    addr_w2_d = addr_w2_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {8'h00, a};
            mplier_d = b;
            acc_d    = 16'h0000;
            cnt_d    = 3'd0;
            dst_d    = dst;
          end else begin
            state_d   = S_DONE;
            buf_w1_d  = alu_res;
            buf_w2_d  = alu_res;
            addr_w1_d = dst;
            addr_w2_d = dst;
            zf_d      = (alu_res == 8'h00);
            cf_d      = alu_cf;
          end
        end
      end
      S_MUL: begin
        acc_d    = prod_next;
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = S_DONE;
          buf_w1_d  = prod_next[7:0];
          buf_w2_d  = prod_next[15:8];
          addr_w1_d = dst_q;
          addr_w2_d = dst_q + 3'd1;
          zf_d      = (prod_next == 16'h0000);
          cf_d      = (prod_next[15:8] != 8'h00);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= 16'h0000;
      mplier_q  <= 8'h00;
      acc_q     <= 16'h0000;
      cnt_q     <= 3'd0;
      dst_q     <= 3'd0;
      buf_w1_q  <= 8'h00;
      buf_w2_q  <= 8'h00;
      addr_w1_q <= 3'd0;
      addr_w2_q <= 3'd0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dst_q     <= dst_d;
      buf_w1_q  <= buf_w1_d;
      buf_w2_q  <= buf_w2_d;
      addr_w1_q <= addr_w1_d;
      addr_w2_q <= addr_w2_d;
      zf_q      <= zf_d;
      cf_q      <= cf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign w_En      = done;
  assign buf_w1    = buf_w1_q;
  assign buf_w2    = buf_w2_q;
  assign addr_w1   = addr_w1_q;
  assign addr_w2   = addr_w2_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: reset, ALU ops, multiply timing/results, back-to-back issue, mid-op reset.
// Inputs change at the falling edge; outputs are sampled 1ns after the rising edge.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] dst = 3'd0;
  logic       busy, done, w_En, zf, cf;
  logic [7:0] buf_w1, buf_w2;
  logic [2:0] addr_w1, addr_w2;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .done(done), .w_En(w_En), .buf_w1(buf_w1), .buf_w2(buf_w2),
    .addr_w1(addr_w1), .addr_w2(addr_w2), .zf(zf), .cf(cf), .dbg_state(dbg_state)
  );

  // Drives one request at the falling edge and returns 1ns after the accepting rising edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] d);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; dst = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_vec++;
    if ({busy, done, w_En, zf, cf, buf_w1, buf_w2, addr_w1, addr_w2} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0",
               {busy, done, w_En, zf, cf, buf_w1, buf_w2, addr_w1, addr_w2});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    issue(3'd0, 8'hF0, 8'h20, 3'd2);
    n_vec++;
    if ({done, w_En, busy, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf} !== {3'b111, 8'h10, 8'h10, 3'd2, 3'd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_done: got %h want %h", {done, w_En, busy, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf},
               {3'b111, 8'h10, 8'h10, 3'd2, 3'd2, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({done, w_En, busy, buf_w1, buf_w2, cf} !== {3'b000, 8'h10, 8'h10, 1'b1}) begin
      n_err++;
      $display("FAIL add_idle_hold: got %h want %h", {done, w_En, busy, buf_w1, buf_w2, cf},
               {3'b000, 8'h10, 8'h10, 1'b1});
    end
  endtask

  task automatic test_sub;
    issue(3'd1, 8'h05, 8'h05, 3'd1);
    n_vec++;
    if ({done, buf_w1, buf_w2, addr_w1, addr_w2, zf, cf} !== {1'b1, 8'h00, 8'h00, 3'd1, 3'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sub_zero: got %h want %h", {done, buf_w1, buf_w2, addr_w1, addr_w2, zf, cf},
               {1'b1, 8'h00, 8'h00, 3'd1, 3'd1, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    issue(3'd1, 8'h03, 8'h05, 3'd1);
    n_vec++;
    if ({done, buf_w1, buf_w2, zf, cf} !== {1'b1, 8'hFE, 8'hFE, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL sub_borrow: got %h want %h", {done, buf_w1, buf_w2, zf, cf},
               {1'b1, 8'hFE, 8'hFE, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_logic_shift;
    logic [2:0] o; logic [7:0] av, bv, res; logic ecf;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin o = 3'd2; av = 8'hA5; bv = 8'h3C; res = 8'h24; ecf = 1'b0; end
        1: begin o = 3'd3; av = 8'hA5; bv = 8'h3C; res = 8'hBD; ecf = 1'b0; end
        2: begin o = 3'd4; av = 8'hA5; bv = 8'h5A; res = 8'hFF; ecf = 1'b0; end
        3: begin o = 3'd4; av = 8'h3C; bv = 8'h3C; res = 8'h00; ecf = 1'b0; end
        4: begin o = 3'd5; av = 8'h81; bv = 8'h00; res = 8'h02; ecf = 1'b1; end
        5: begin o = 3'd6; av = 8'h81; bv = 8'h00; res = 8'h40; ecf = 1'b1; end
        6: begin o = 3'd5; av = 8'h40; bv = 8'hFF; res = 8'h80; ecf = 1'b0; end
        default: begin o = 3'd0; av = 8'hFF; bv = 8'h01; res = 8'h00; ecf = 1'b1; end
      endcase
      issue(o, av, bv, 3'(i));
      n_vec++;
      if ({done, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf} !== {1'b1, res, res, 3'(i), 3'(i), ecf, res == 8'h00}) begin
        n_err++;
        $display("FAIL alu_vec%0d op%0d: got %h want %h", i, o,
                 {done, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf},
                 {1'b1, res, res, 3'(i), 3'(i), ecf, res == 8'h00});
      end
      @(posedge clk); #1;
    end
  endtask

  // Multiply: busy for 8 cycles with done low, done on cycle 9; operands and a stray start are scrambled mid-op.
  task automatic mul_case(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] d,
                          input logic [15:0] prod);
    logic [2:0] d2;
    d2 = d + 3'd1;
    issue(3'd7, av, bv, d);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin a = 8'h5A; b = 8'hC3; dst = 3'd6; end
      if (c == 3) begin start = 1'b1; op = 3'd0; end
      if (c == 6) start = 1'b0;
      n_vec++;
      if ({busy, done, w_En} !== 3'b100) begin
        n_err++;
        $display("FAIL mul_cycle%0d: busy/done/w_En got %b want 100", c, {busy, done, w_En});
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if ({busy, done, w_En, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf} !==
        {3'b111, prod[7:0], prod[15:8], d, d2, prod[15:8] != 8'h00, prod == 16'h0000}) begin
      n_err++;
      $display("FAIL mul_done %h*%h: got %h want %h", av, bv,
               {busy, done, w_En, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf},
               {3'b111, prod[7:0], prod[15:8], d, d2, prod[15:8] != 8'h00, prod == 16'h0000});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL mul_return_idle: busy/done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_mul;
    mul_case(8'hFF, 8'hFF, 3'd7, 16'hFE01);
    mul_case(8'h00, 8'h7F, 3'd3, 16'h0000);
    mul_case(8'h12, 8'h34, 3'd5, 16'h03A8);
    mul_case(8'h0F, 8'h11, 3'd0, 16'h00FF);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01; dst = 3'd4;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (done !== ((i % 2) == 0)) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: done got %b want %b", i, done, (i % 2) == 0);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid_mul;
    logic saw_done;
    issue(3'd7, 8'hFF, 8'hFF, 3'd7);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, w_En, zf, cf, buf_w1, buf_w2, addr_w1, addr_w2} !== 25'd0) begin
      n_err++;
      $display("FAIL rst_mid_mul: got %h want 0",
               {busy, done, w_En, zf, cf, buf_w1, buf_w2, addr_w1, addr_w2});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || w_En || busy) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_abort: activity after abort got 1 want 0");
    end
    issue(3'd0, 8'h7F, 8'h01, 3'd4);
    n_vec++;
    if ({done, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf} !== {1'b1, 8'h80, 8'h80, 3'd4, 3'd4, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_after_rst: got %h want %h", {done, buf_w1, buf_w2, addr_w1, addr_w2, cf, zf},
               {1'b1, 8'h80, 8'h80, 3'd4, 3'd4, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic_shift;
    test_mul;
    test_back_to_back;
    test_rst_mid_mul;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
